// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard controller: load-use and MDU stalls, PC redirect mux, EX flush, perf counters.
// Outputs are combinational from state and inputs; ex_jmp_vld overrides any stall.
module hazard_ctrl_p #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              id_jmp_vld,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_jmp_vld,
  input  logic [XLEN-1:0]   ex_jmp_addr,
  input  logic              mdu_busy,
  output logic              hold_if,
  output logic              nop_id,
  output logic              jmp_vld_if,
  output logic [XLEN-1:0]   jmp_addr_if,
  output logic              inst_vld_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0]       S_RUN   = 2'd0;
  localparam logic [1:0]       S_LU    = 2'd1;
  localparam logic [1:0]       S_MDU   = 2'd2;
  localparam logic [2:0]       LU_INIT = 3'(LOAD_STALL - 1);
  localparam logic [2:0]       FL_INIT = 3'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       lu_rem_q, lu_rem_d;
  logic [2:0]       fl_rem_q, fl_rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu, shadow, hold;

  assign lu = ex_is_load && (ex_rd != '0)
              && ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
  // Anything seen in ID while EX redirects or the flush drains is wrong-path.
  assign shadow = ex_jmp_vld || (fl_rem_q != 3'd0);

  always_comb begin
    state_d  = state_q;
    lu_rem_d = lu_rem_q;
    hold     = 1'b0;
    if (ex_jmp_vld) begin
      state_d  = S_RUN;
      lu_rem_d = 3'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (lu && !shadow) begin
            hold = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d  = S_LU;
              lu_rem_d = LU_INIT;
            end
          end else if (mdu_busy) begin
            hold    = 1'b1;
            state_d = S_MDU;
          end
        end
        S_LU: begin
          hold     = 1'b1;
          lu_rem_d = lu_rem_q - 3'd1;
          if (lu_rem_q <= 3'd1) begin
            state_d  = S_RUN;
            lu_rem_d = 3'd0;
          end
        end
        S_MDU: begin
          if (mdu_busy) hold = 1'b1;
          else          state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    fl_rem_d = fl_rem_q;
    if (ex_jmp_vld)              fl_rem_d = FL_INIT;
    else if (fl_rem_q != 3'd0)   fl_rem_d = fl_rem_q - 3'd1;
  end

  always_comb begin
    jmp_vld_if  = 1'b0;
    jmp_addr_if = '0;
    if (!rst) begin
      if (ex_jmp_vld) begin
        jmp_vld_if  = 1'b1;
        jmp_addr_if = ex_jmp_addr;
      end else if (id_jmp_vld && !shadow && !hold) begin
        jmp_vld_if  = 1'b1;
        jmp_addr_if = id_pc + id_imm;
      end
    end
  end

  assign hold_if     = hold && !rst;
  assign nop_id      = hold && !rst;
  assign inst_vld_ex = !rst && !ex_jmp_vld && (fl_rem_q == 3'd0);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      lu_rem_q    <= 3'd0;
      fl_rem_q    <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_rem_q <= lu_rem_d;
      fl_rem_q <= fl_rem_d;
      if (hold && (stall_cnt_q != CNT_MAX))       stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_jmp_vld && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Self-checking bench for hazard_ctrl_p: defaults, LOAD_STALL=3 and CNT_W=4 instances share stimulus.
module tb_hazard_ctrl_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, id_jmp_vld, ex_jmp_vld, mdu_busy;
  logic [31:0] id_imm, id_pc, ex_jmp_addr;

  logic        hold_a, nop_a, jv_a, iv_a;
  logic [31:0] addr_a;
  logic [15:0] sc_a, fc_a;
  logic        hold_b, nop_b, jv_b, iv_b;
  logic [31:0] addr_b;
  logic [15:0] sc_b, fc_b;
  logic        hold_c, nop_c, jv_c, iv_c;
  logic [31:0] addr_c;
  logic [3:0]  sc_c, fc_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl_p u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .id_jmp_vld(id_jmp_vld),
    .id_imm(id_imm), .id_pc(id_pc), .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
    .mdu_busy(mdu_busy), .hold_if(hold_a), .nop_id(nop_a), .jmp_vld_if(jv_a),
    .jmp_addr_if(addr_a), .inst_vld_ex(iv_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_ctrl_p #(.LOAD_STALL(3)) u_ls3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .id_jmp_vld(id_jmp_vld),
    .id_imm(id_imm), .id_pc(id_pc), .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
    .mdu_busy(mdu_busy), .hold_if(hold_b), .nop_id(nop_b), .jmp_vld_if(jv_b),
    .jmp_addr_if(addr_b), .inst_vld_ex(iv_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  hazard_ctrl_p #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .id_jmp_vld(id_jmp_vld),
    .id_imm(id_imm), .id_pc(id_pc), .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
    .mdu_busy(mdu_busy), .hold_if(hold_c), .nop_id(nop_c), .jmp_vld_if(jv_c),
    .jmp_addr_if(addr_c), .inst_vld_ex(iv_c), .stall_cnt(sc_c), .flush_cnt(fc_c));

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        ld;
    logic        idj;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        exj;
    logic [31:0] exa;
    logic        mdu;
  } in_t;

  typedef struct packed {
    logic        hold;
    logic        jv;
    logic [31:0] addr;
    logic        iv;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[9];

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic ld,
                             input logic idj, input logic [31:0] pc, input logic [31:0] imm);
    in_t v;
    v = '0;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld;
    v.idj = idj; v.pc = pc; v.imm = imm;
    return v;
  endfunction

  function automatic exp_t mke(input logic hold, input logic jv, input logic [31:0] addr,
                               input logic iv);
    exp_t e;
    e.hold = hold; e.jv = jv; e.addr = addr; e.iv = iv;
    return e;
  endfunction

  task automatic set_in(input in_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; id_jmp_vld = v.idj; id_pc = v.pc; id_imm = v.imm;
    ex_jmp_vld = v.exj; ex_jmp_addr = v.exa; mdu_busy = v.mdu;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  // Pops the oldest expectation and compares it against the default instance.
  task automatic chk_pop(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got none, expected entry", nm);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".hold"}, {31'd0, hold_a}, {31'd0, e.hold});
    chk({nm, ".nop"},  {31'd0, nop_a},  {31'd0, e.hold});
    chk({nm, ".jv"},   {31'd0, jv_a},   {31'd0, e.jv});
    chk({nm, ".addr"}, addr_a,          e.addr);
    chk({nm, ".iv"},   {31'd0, iv_a},   {31'd0, e.iv});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  in_t hit, v;

  initial begin
    rst = 1'b1;
    set_in('0);
    hit = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);

    #2;
    chk("rst.iv_a", {31'd0, iv_a}, 32'd0);
    chk("rst.iv_b", {31'd0, iv_b}, 32'd0);

    do_reset();
    @(negedge clk);
    chk("reset.hold", {31'd0, hold_a}, 32'd0);
    chk("reset.iv",   {31'd0, iv_a},   32'd1);
    chk("reset.jv",   {31'd0, jv_a},   32'd0);
    chk("reset.sc",   {16'd0, sc_a},   32'd0);
    chk("reset.fc",   {16'd0, fc_a},   32'd0);

    tbl[0] = '{mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0), mke(1'b0, 1'b0, 32'h0, 1'b1)};
    tbl[1] = '{hit, mke(1'b1, 1'b0, 32'h0, 1'b1)};
    tbl[2] = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0), mke(1'b0, 1'b0, 32'h0, 1'b1)};
    tbl[3] = '{mk(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0), mke(1'b0, 1'b0, 32'h0, 1'b1)};
    tbl[4] = '{mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0), mke(1'b1, 1'b0, 32'h0, 1'b1)};
    tbl[5] = '{mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 32'h40, 32'h20), mke(1'b0, 1'b1, 32'h60, 1'b1)};
    tbl[6] = '{mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20), mke(1'b0, 1'b1, 32'h10, 1'b1)};
    tbl[7] = '{mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'h40, 32'h20), mke(1'b1, 1'b0, 32'h0, 1'b1)};
    tbl[8] = '{mk(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0), mke(1'b0, 1'b0, 32'h0, 1'b1)};

    for (int k = 0; k < 9; k++) begin
      next_cyc();
      set_in(tbl[k].i);
      exp_q.push_back(tbl[k].e);
      @(negedge clk);
      chk_pop($sformatf("vec%0d", k));
    end
    next_cyc();
    set_in('0);
    @(negedge clk);
    chk("tbl.stall_cnt", {16'd0, sc_a}, 32'd3);
    chk("tbl.flush_cnt", {16'd0, fc_a}, 32'd0);

    // Three-bubble load-use on the LOAD_STALL=3 instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      if (k == 0) set_in(hit);
      else        set_in('0);
      @(negedge clk);
      chk($sformatf("ls3.hold%0d", k), {31'd0, hold_b}, {31'd0, (k < 3)});
      if (k == 1) chk("ls1.single_bubble", {31'd0, hold_a}, 32'd0);
    end
    chk("ls3.stall_cnt", {16'd0, sc_b}, 32'd3);

    // EX redirect beats ID jump; wrong-path ID jump ignored during flush.
    do_reset();
    v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h40, 32'h20);
    v.exj = 1'b1;
    v.exa = 32'h100;
    next_cyc(); set_in(v); exp_q.push_back(mke(1'b0, 1'b1, 32'h100, 1'b0));
    @(negedge clk); chk_pop("redir0");
    v.exj = 1'b0;
    next_cyc(); set_in(v); exp_q.push_back(mke(1'b0, 1'b0, 32'h0, 1'b0));
    @(negedge clk); chk_pop("redir1");
    next_cyc(); set_in('0); exp_q.push_back(mke(1'b0, 1'b0, 32'h0, 1'b1));
    @(negedge clk); chk_pop("redir2");
    chk("redir.flush_cnt", {16'd0, fc_a}, 32'd1);

    // MDU busy for four cycles.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      v = '0;
      v.mdu = (k < 4);
      set_in(v);
      exp_q.push_back(mke((k < 4), 1'b0, 32'h0, 1'b1));
      @(negedge clk);
      chk_pop($sformatf("mdu%0d", k));
    end
    chk("mdu.stall_cnt", {16'd0, sc_a}, 32'd4);

    // EX redirect cuts a LU_STALL short.
    do_reset();
    next_cyc(); set_in(hit);
    @(negedge clk); chk("cut0.hold", {31'd0, hold_b}, 32'd1);
    next_cyc(); set_in('0);
    @(negedge clk); chk("cut1.hold", {31'd0, hold_b}, 32'd1);
    v = '0; v.exj = 1'b1; v.exa = 32'h200;
    next_cyc(); set_in(v);
    @(negedge clk);
    chk("cut2.hold", {31'd0, hold_b}, 32'd0);
    chk("cut2.jv",   {31'd0, jv_b},   32'd1);
    chk("cut2.addr", addr_b,          32'h200);
    chk("cut2.iv",   {31'd0, iv_b},   32'd0);
    next_cyc(); set_in('0);
    @(negedge clk);
    chk("cut3.hold", {31'd0, hold_b}, 32'd0);
    chk("cut3.iv",   {31'd0, iv_b},   32'd0);
    chk("cut.stall_cnt", {16'd0, sc_b}, 32'd2);
    chk("cut.flush_cnt", {16'd0, fc_b}, 32'd1);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    next_cyc(); set_in(hit);
    @(negedge clk); chk("ar0.hold", {31'd0, hold_b}, 32'd1);
    next_cyc(); set_in('0);
    #2 chk("ar1.hold", {31'd0, hold_b}, 32'd1);
    rst = 1'b1;
    v = '0; v.exj = 1'b1; v.exa = 32'h300;
    set_in(v);
    #1;
    chk("ar.hold", {31'd0, hold_b}, 32'd0);
    chk("ar.nop",  {31'd0, nop_b},  32'd0);
    chk("ar.jv",   {31'd0, jv_b},   32'd0);
    chk("ar.addr", addr_b,          32'h0);
    chk("ar.iv",   {31'd0, iv_b},   32'd0);
    chk("ar.sc",   {16'd0, sc_b},   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_in('0);
    @(negedge clk);
    chk("ar.after.hold", {31'd0, hold_b}, 32'd0);
    chk("ar.after.iv",   {31'd0, iv_b},   32'd1);

    // Counter saturation with CNT_W=4.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      next_cyc();
      v = '0; v.mdu = 1'b1;
      set_in(v);
    end
    next_cyc(); set_in('0);
    @(negedge clk);
    chk("sat.sc_c", {28'd0, sc_c}, 32'd15);
    chk("sat.sc_a", {16'd0, sc_a}, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
